// File: rtl/hist2d_accumulator.sv
// rtl/hist2d_accumulator.sv - 2D histogram bin accumulator with streamed dump readout
// Optional HIST_CLEAR_ON_READ_EN: dump zeroes each bin as it is read out.
module hist2d_accumulator #(
  parameter int I_BITS  = 6,
  parameter int Q_BITS  = 6,
  parameter int COUNT_W = 16
) (
  input  logic               clk100,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [I_BITS-1:0]  i_bin_coord,
  input  logic [Q_BITS-1:0]  q_bin_coord,
  input  logic               dump_req,
  input  logic               clear_req,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [I_BITS-1:0]  out_i_coord,
  output logic [Q_BITS-1:0]  out_q_coord,
  output logic [COUNT_W-1:0] out_bin_val,
  output logic               out_last,
  output logic               busy,
  output logic [15:0]        drop_count,
  output logic [31:0]        sample_count
);

  localparam int AW = I_BITS + Q_BITS;
  localparam logic [AW-1:0] AMAX = '1;

  typedef enum logic [1:0] {S_CLEAR, S_ACCUM, S_DRAIN, S_DUMP} state_t;

  state_t state, state_n;

  logic [COUNT_W-1:0] mem [0:(1<<AW)-1];
  logic [COUNT_W-1:0] rd_data;
  logic [AW-1:0]      rd_addr;
  logic               wr_en;
  logic [AW-1:0]      wr_addr;
  logic [COUNT_W-1:0] wr_data;

  logic [AW-1:0]      clr_addr;
  logic               drain_clr;

  logic               s1_valid, s2_valid, w_valid;
  logic [AW-1:0]      s1_addr, s2_addr, w_addr;
  logic [COUNT_W-1:0] s2_val, w_val, base;

  logic [AW:0]        dump_ptr;
  logic [AW-1:0]      fetch_addr;
  logic               rd_pend;

  logic accept, xfer, fetch, enter_clear;

  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
    return (&v) ? v : v + COUNT_W'(1);
  endfunction

  assign in_ready    = (state == S_ACCUM);
  assign busy        = (state != S_ACCUM);
  assign accept      = in_valid && in_ready;
  assign xfer        = out_valid && out_ready;
  assign enter_clear = (state != S_CLEAR) && (state_n == S_CLEAR);
  // Next word is fetched as soon as the output register is free or emptying.
  assign fetch       = (state == S_DUMP) && !clear_req && !rd_pend &&
                       (!out_valid || xfer) && !dump_ptr[AW];

  // Read data misses the two most recent updates; take the newest matching one.
  always_comb begin
    base = rd_data;
    if (s2_valid && s2_addr == s1_addr)
      base = s2_val;
    else if (w_valid && w_addr == s1_addr)
      base = w_val;
  end

  always_comb begin
    wr_en   = 1'b0;
    wr_addr = clr_addr;
    wr_data = '0;
    if (state == S_CLEAR) begin
      wr_en = 1'b1;
    end else if (s2_valid) begin
      wr_en   = 1'b1;
      wr_addr = s2_addr;
      wr_data = s2_val;
    end
`ifdef HIST_CLEAR_ON_READ_EN
    else if (state == S_DUMP && xfer) begin
      wr_en   = 1'b1;
      wr_addr = {out_i_coord, out_q_coord};
      wr_data = '0;
    end
`endif
  end

  assign rd_addr = (state == S_DUMP) ? dump_ptr[AW-1:0] : {i_bin_coord, q_bin_coord};

  always_ff @(posedge clk100) begin
    if (wr_en)
      mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

  always_comb begin
    state_n = state;
    case (state)
      S_CLEAR: if (clr_addr == AMAX) state_n = S_ACCUM;
      S_ACCUM: if (clear_req || dump_req) state_n = S_DRAIN;
      S_DRAIN: if (!s1_valid && !s2_valid)
                 state_n = (drain_clr || clear_req) ? S_CLEAR : S_DUMP;
      S_DUMP:  if (clear_req) state_n = S_CLEAR;
               else if (xfer && out_last) state_n = S_ACCUM;
      default: state_n = S_CLEAR;
    endcase
  end

  always_ff @(posedge clk100 or posedge reset) begin
    if (reset) begin
      state        <= S_CLEAR;
      clr_addr     <= '0;
      drain_clr    <= 1'b0;
      s1_valid     <= 1'b0;
      s1_addr      <= '0;
      s2_valid     <= 1'b0;
      s2_addr      <= '0;
      s2_val       <= '0;
      w_valid      <= 1'b0;
      w_addr       <= '0;
      w_val        <= '0;
      dump_ptr     <= '0;
      fetch_addr   <= '0;
      rd_pend      <= 1'b0;
      out_valid    <= 1'b0;
      out_last     <= 1'b0;
      out_i_coord  <= '0;
      out_q_coord  <= '0;
      out_bin_val  <= '0;
      drop_count   <= '0;
      sample_count <= '0;
    end else begin
      state <= state_n;

      if (enter_clear)
        clr_addr <= '0;
      else if (state == S_CLEAR)
        clr_addr <= clr_addr + AW'(1);

      if (state == S_ACCUM)
        drain_clr <= clear_req;
      else if (clear_req)
        drain_clr <= 1'b1;

      s1_valid <= accept;
      if (accept)
        s1_addr <= {i_bin_coord, q_bin_coord};
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_addr <= s1_addr;
        s2_val  <= sat_inc(base);
      end
      w_valid <= s2_valid;
      w_addr  <= s2_addr;
      w_val   <= s2_val;

      if (enter_clear)
        sample_count <= '0;
`ifdef HIST_CLEAR_ON_READ_EN
      else if (state == S_DUMP && state_n == S_ACCUM)
        sample_count <= '0;
`endif
      else if (accept)
        sample_count <= sample_count + 32'd1;

      if (enter_clear)
        drop_count <= '0;
      else if (in_valid && !in_ready && drop_count != 16'hFFFF)
        drop_count <= drop_count + 16'd1;

      if (state != S_DUMP)
        dump_ptr <= '0;
      else if (fetch)
        dump_ptr <= dump_ptr + (AW+1)'(1);
      if (fetch)
        fetch_addr <= dump_ptr[AW-1:0];
      rd_pend <= fetch;

      if (state == S_DUMP && clear_req) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end else if (rd_pend) begin
        out_valid   <= 1'b1;
        out_i_coord <= fetch_addr[AW-1:Q_BITS];
        out_q_coord <= fetch_addr[Q_BITS-1:0];
        out_bin_val <= rd_data;
        out_last    <= (fetch_addr == AMAX);
      end else if (xfer) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_hist2d_accumulator.sv
// tb/tb_hist2d_accumulator.sv - self-checking bench for hist2d_accumulator (2x2-bit bins, 2-bit counts)
module tb_hist2d_accumulator;

  localparam int NB   = 16;
  localparam int CMAX = 3;

  logic       clk100 = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] i_bin_coord;
  logic [1:0] q_bin_coord;
  logic       dump_req;
  logic       clear_req;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] out_i_coord;
  logic [1:0] out_q_coord;
  logic [1:0] out_bin_val;
  logic       out_last;
  logic       busy;
  logic [15:0] drop_count;
  logic [31:0] sample_count;

  hist2d_accumulator #(.I_BITS(2), .Q_BITS(2), .COUNT_W(2)) dut (
    .clk100(clk100), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .i_bin_coord(i_bin_coord), .q_bin_coord(q_bin_coord),
    .dump_req(dump_req), .clear_req(clear_req),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_i_coord(out_i_coord), .out_q_coord(out_q_coord),
    .out_bin_val(out_bin_val), .out_last(out_last), .busy(busy),
    .drop_count(drop_count), .sample_count(sample_count)
  );

  always #5 clk100 = ~clk100;

  typedef struct {
    int         phase;
    logic [1:0] i;
    logic [1:0] q;
    int         exp;
    bit         fin;
  } vec_t;

  typedef struct {
    logic [3:0] addr;
    logic [1:0] val;
    logic       last;
  } word_t;

  vec_t  vecs[17];
  word_t exp_q[$];
  int    model[NB];
  int    got[NB];
  int    n_vec = 0;
  int    n_bad = 0;
  int    xfer_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk100);
    #1;
  endtask

  // Scoreboard monitor: sampled on the falling edge, pops one expected word per transfer.
  logic       stall_prev = 1'b0;
  logic [6:0] hold_word;
  always @(negedge clk100) begin
    if (reset) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev)
        check("hold_stable", 32'({out_valid, out_i_coord, out_q_coord, out_bin_val, out_last}),
              32'({1'b1, hold_word}));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_word: got addr %0d, expected no word", {out_i_coord, out_q_coord});
        end else begin
          word_t e;
          e = exp_q.pop_front();
          check("dump_word", 32'({out_i_coord, out_q_coord, out_bin_val, out_last}),
                32'({e.addr, e.val, e.last}));
          got[e.addr] = int'(out_bin_val);
        end
        xfer_cnt++;
      end
      stall_prev = out_valid && !out_ready && !clear_req;
      hold_word  = {out_i_coord, out_q_coord, out_bin_val, out_last};
    end
  end

  task automatic send(input logic [1:0] i, input logic [1:0] q);
    int b = 0;
    in_valid    = 1'b1;
    i_bin_coord = i;
    q_bin_coord = q;
    while (!in_ready && b < 50) begin
      tick();
      b++;
    end
    if (!in_ready) check("send_timeout_in_ready", 32'(in_ready), 32'd1);
    tick();
    if (model[{i, q}] < CMAX) model[{i, q}]++;
  endtask

  task automatic wait_idle(input string name);
    int b = 0;
    while (busy && b < 100) begin
      tick();
      b++;
    end
    check(name, 32'(busy), 32'd0);
  endtask

  task automatic do_dump(input bit toggle, input int abort_at);
    int cyc = 0;
    bit aborted = 0;
    for (int a = 0; a < NB; a++) begin
      word_t w;
      w.addr = 4'(a);
      w.val  = 2'(model[a]);
      w.last = (a == NB - 1);
      exp_q.push_back(w);
      got[a] = -1;
`ifdef HIST_CLEAR_ON_READ_EN
      model[a] = 0;
`endif
    end
    xfer_cnt = 0;
    dump_req = 1'b1;
    tick();
    dump_req = 1'b0;
    while (exp_q.size() > 0 && cyc < 300) begin
      if (abort_at >= 0 && xfer_cnt == abort_at && out_valid) begin
        int  b = 0;
        bit  seen = 0;
        out_ready = 1'b0;
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd1);
        exp_q.delete();
        aborted = 1;
        while (busy && b < 100) begin
          if (out_valid) seen = 1;
          tick();
          b++;
        end
        check("abort_no_words", 32'(seen), 32'd0);
        check("abort_clear_done", 32'(busy), 32'd0);
        for (int a = 0; a < NB; a++) model[a] = 0;
        break;
      end
      out_ready = toggle ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      tick();
      cyc++;
    end
    out_ready = 1'b0;
    if (!aborted) begin
      check("dump_words_left", 32'(exp_q.size()), 32'd0);
      check("dump_end_out_valid", 32'(out_valid), 32'd0);
      check("dump_end_busy", 32'(busy), 32'd0);
    end
  endtask

  task automatic run_phase(input int ph, input bit toggle);
    for (int k = 0; k < 17; k++)
      if (vecs[k].phase == ph) send(vecs[k].i, vecs[k].q);
    in_valid = 1'b0;
    tick();
    do_dump(toggle, -1);
    for (int k = 0; k < 17; k++)
      if (vecs[k].phase == ph && vecs[k].fin)
        check($sformatf("bin_%0d_%0d", vecs[k].i, vecs[k].q), 32'(got[{vecs[k].i, vecs[k].q}]),
              32'(vecs[k].exp));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{1, 2'd1, 2'd2, 1, 0};
    vecs[1]  = '{1, 2'd1, 2'd2, 2, 0};
    vecs[2]  = '{1, 2'd1, 2'd2, 3, 1};
    vecs[3]  = '{1, 2'd3, 2'd3, 1, 1};
    vecs[4]  = '{2, 2'd0, 2'd0, 1, 0};
    vecs[5]  = '{2, 2'd0, 2'd0, 2, 0};
    vecs[6]  = '{2, 2'd0, 2'd0, 3, 0};
    vecs[7]  = '{2, 2'd0, 2'd0, 3, 0};
    vecs[8]  = '{2, 2'd0, 2'd0, 3, 1};
    vecs[9]  = '{3, 2'd0, 2'd1, 1, 0};
    vecs[10] = '{3, 2'd0, 2'd1, 2, 0};
    vecs[11] = '{3, 2'd2, 2'd3, 1, 0};
    vecs[12] = '{3, 2'd2, 2'd3, 2, 0};
    vecs[13] = '{3, 2'd2, 2'd3, 3, 1};
    vecs[14] = '{3, 2'd3, 2'd0, 1, 1};
    vecs[15] = '{3, 2'd0, 2'd1, 3, 1};
    vecs[16] = '{3, 2'd1, 2'd1, 1, 1};
    for (int a = 0; a < NB; a++) model[a] = 0;

    reset = 1'b1; in_valid = 1'b0; i_bin_coord = '0; q_bin_coord = '0;
    dump_req = 1'b0; clear_req = 1'b0; out_ready = 1'b0;
    repeat (3) tick();
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_out_word", 32'({out_i_coord, out_q_coord, out_bin_val}), 32'd0);
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_drop_count", 32'(drop_count), 32'd0);
    check("rst_sample_count", sample_count, 32'd0);

    // Reset CLEAR sweep with in_valid held: 16 busy cycles, 16 drops.
    @(negedge clk100);
    reset    = 1'b0;
    in_valid = 1'b1;
    for (int k = 0; k < 16; k++) begin
      tick();
      if (k < 15) check("clear_busy", 32'(busy), 32'd1);
    end
    in_valid = 1'b0;
    check("clear_done_busy", 32'(busy), 32'd0);
    check("clear_done_in_ready", 32'(in_ready), 32'd1);
    check("clear_drop_count", 32'(drop_count), 32'd16);
    check("clear_sample_count", sample_count, 32'd0);

    // Back-to-back identical coordinates, then two consecutive dumps.
    run_phase(1, 1'b0);
    check("last_flagged_bin", 32'(got[15]), 32'd1);
`ifdef HIST_CLEAR_ON_READ_EN
    check("p1_sample_count", sample_count, 32'd0);
`else
    check("p1_sample_count", sample_count, 32'd4);
`endif
    do_dump(1'b0, -1);

    // Explicit clear, then saturation at 3.
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    wait_idle("clear_req_done");
    for (int a = 0; a < NB; a++) model[a] = 0;
    check("clear_req_sample_count", sample_count, 32'd0);
    run_phase(2, 1'b0);

    // Mixed bins with a stalling consumer.
    run_phase(3, 1'b1);

    // Abort at word 5, then the histogram must read back all zeros.
    do_dump(1'b0, 5);
    check("abort_sample_count", sample_count, 32'd0);
    do_dump(1'b0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
